// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit owning the HI/LO pair.
// The full result is computed at issue and parked in pend_*; a down-counter
// models the execution latency, and HI/LO update only when it expires.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | no op in flight; accepts MULT*/DIV*/MADD/MSUB/MTHI/MTLO
// S_MULT_RUN | multiply-class op in flight, counting MULT_CYCLES
// S_DIV_RUN  | divide op in flight, counting DIV_CYCLES
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_MULT_RUN, S_DIV_RUN} state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic                 busy_q;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic [WIDTH-1:0]     pend_hi_q, pend_lo_q;
    logic [2*WIDTH-1:0]   res_d;

    logic [2*WIDTH-1:0]   prod_s, prod_u, acc;
    logic                 b_zero, div_ovf;
    logic [WIDTH-1:0]     div_b_s, div_b_u;
    logic signed [WIDTH-1:0] q_s, r_s;
    logic [WIDTH-1:0]     q_u, r_u;

    // Full-width result of the op on the issue-edge operands and HI/LO.
    // Zero and overflow divisors are replaced by 1 so the dividers never
    // see an undefined case; those results come from the special branches.
    always_comb begin
        acc     = {hi_q, lo_q};
        prod_s  = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        prod_u  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        b_zero  = (b == '0);
        div_ovf = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
        div_b_s = (b_zero || div_ovf) ? WIDTH'(1) : b;
        div_b_u = b_zero ? WIDTH'(1) : b;
        q_s     = $signed(a) / $signed(div_b_s);
        r_s     = $signed(a) % $signed(div_b_s);
        q_u     = a / div_b_u;
        r_u     = a % div_b_u;
        res_d   = acc;
        case (op)
            OP_MULT:  res_d = prod_s;
            OP_MULTU: res_d = prod_u;
            OP_DIV: begin
                if (b_zero)       res_d = {a, {WIDTH{1'b1}}};
                else if (div_ovf) res_d = {{WIDTH{1'b0}}, a};
                else              res_d = {r_s, q_s};
            end
            OP_DIVU:  res_d = b_zero ? {a, {WIDTH{1'b1}}} : {r_u, q_u};
            OP_MADD:  res_d = acc + prod_s;
            OP_MSUB:  res_d = acc - prod_s;
            default:  res_d = acc;
        endcase
    end

    // Issue / count-down / commit FSM with registered busy and HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MTHI: hi_q <= a;
                            OP_MTLO: lo_q <= a;
                            default: begin
                                pend_hi_q <= res_d[2*WIDTH-1:WIDTH];
                                pend_lo_q <= res_d[WIDTH-1:0];
                                busy_q    <= 1'b1;
                                if (op == OP_DIV || op == OP_DIVU) begin
                                    cnt_q   <= CW'(DIV_CYCLES);
                                    state_q <= S_DIV_RUN;
                                end else begin
                                    cnt_q   <= CW'(MULT_CYCLES);
                                    state_q <= S_MULT_RUN;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    // starts are ignored while an op is in flight
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        hi_q    <= pend_hi_q;
                        lo_q    <= pend_lo_q;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with its own HI/LO register pair.
- Sits in the EX stage of the pipelined MIPS core, beside the ALU.
- Performs signed and unsigned multiply and divide, signed multiply-accumulate and multiply-subtract, and MTHI/MTLO.
- Models a configurable execution latency with a busy flag, which hazard control uses to stall MF*/MD instructions.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits.
- MULT_CYCLES, 5, busy cycles for MULT/MULTU/MADD/MSUB (>=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; reset=0 clears all state.
- start  input  1  issue strobe from EX, sampled on a rising clk edge.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD (signed), 111 MSUB (signed).
- a  input  WIDTH  rs operand.
- b  input  WIDTH  rt operand.
- busy  output  1  high while an arithmetic op is in flight.
- hi  output  WIDTH  architectural HI register.
- lo  output  WIDTH  architectural LO register.

Behaviour:
- Reset
  - reset=0 forces busy=0, hi=0, lo=0, counter=0 and pending result=0 immediately, independent of clk.
  - Reset mid-operation aborts the op; its result is never written.
- States
  - IDLE, MULT_RUN, DIV_RUN.
  - Counter width is $clog2(max(MULT_CYCLES, DIV_CYCLES))+1.
- IDLE
  - start=1 with an arithmetic op at edge t: latch the full result into internal pend_hi/pend_lo, load counter with N (MULT_CYCLES or DIV_CYCLES), and go to the matching RUN state.
  - busy=1 from the cycle after edge t through cycle t+N.
- RUN
  - Counter decrements every edge.
  - On the edge that ends cycle t+N: hi<=pend_hi, lo<=pend_lo, busy->0, return to IDLE.
  - New HI/LO are visible in cycle t+N+1.
- MTHI/MTLO
  - Allowed only in IDLE.
  - Write a into hi or lo at the same edge; busy stays 0.
- start while busy=1: ignored (all op codes); the in-flight result is unaffected. Hazard logic must not issue in this case; the bench checks that the block still ignores it.
- Back-to-back ops
  - start in the first IDLE cycle after completion is accepted.
  - MADD/MSUB operands then see the just-committed HI/LO.
- Arithmetic
  - MULT: {hi,lo} = signed(a)*signed(b), 2*WIDTH-bit product.
  - MULTU: {hi,lo} = unsigned(a)*unsigned(b).
  - MADD: {hi,lo} = {hi,lo} + signed(a)*signed(b), modulo 2^(2*WIDTH). {hi,lo} is sampled at the start edge.
  - MSUB: {hi,lo} = {hi,lo} - signed(a)*signed(b), modulo 2^(2*WIDTH). {hi,lo} is sampled at the start edge.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of a.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (DIV and DIVU): lo = all ones, hi = a. No trap.
- DIV of most-negative by -1: lo = most-negative, hi = 0.
- Operands a and b are sampled only at the start edge; later changes have no effect.

Test Plan (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10):
- Signed vs unsigned multiply: MULT a=FFFFFFFF b=00000002 -> busy high 5 cycles, then hi=FFFFFFFF lo=FFFFFFFE. MULTU with the same operands -> hi=00000001 lo=FFFFFFFE.
- Signed vs unsigned divide: DIV a=FFFFFFF9 (-7) b=2 -> busy high 10 cycles, then lo=FFFFFFFD hi=FFFFFFFF. DIVU a=7 b=2 -> lo=3 hi=1.
- Divide edge cases:
  - DIVU a=00001234 b=0 -> lo=FFFFFFFF hi=00001234.
  - DIV a=80000000 b=FFFFFFFF -> lo=80000000 hi=0.
- Accumulate: MTHI 0, MTLO 5 (busy stays 0, values visible the next cycle); MADD a=3 b=4 -> lo=00000011 hi=0; MSUB a=1 b=00000012 -> hi=FFFFFFFF lo=FFFFFFFF.
- Ignored starts: during a DIV with busy=1, pulse start with MULT and with MTHI a=DEAD -> both ignored; final hi/lo equal the DIV result and busy falls exactly 10 cycles after the original start.
- Reset mid-op: assert reset=0 mid-cycle 4 of a MULT -> busy, hi, lo read 0 before the next clk edge; after release, hi/lo stay 0 and busy stays 0.
